// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesting masters and the memory.
// slave = arbiter side, master = requesters plus memory read-data source.
interface dmem_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          req0;
    logic          we0;
    logic          lock0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          gnt0;
    logic          rvalid0;
    logic [DW-1:0] rdata0;

    logic          req1;
    logic          we1;
    logic          lock1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          gnt1;
    logic          rvalid1;
    logic [DW-1:0] rdata1;

    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    modport slave (
        input  req0, we0, lock0, addr0, wdata0,
        output gnt0, rvalid0, rdata0,
        input  req1, we1, lock1, addr1, wdata1,
        output gnt1, rvalid1, rdata1,
        output mem_we, mem_addr, mem_wd,
        input  mem_rd
    );

    modport master (
        output req0, we0, lock0, addr0, wdata0,
        input  gnt0, rvalid0, rdata0,
        output req1, we1, lock1, addr1, wdata1,
        input  gnt1, rvalid1, rdata1,
        input  mem_we, mem_addr, mem_wd,
        output mem_rd
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the single-ported data memory with bounded ownership lock.
// Define DMEM_ARB_FIXED_PRIO_EN to make port 0 always win contention in IDLE.
module dmem_arbiter #(
    parameter int AW       = 5,
    parameter int DW       = 32,
    parameter int LOCK_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);

    localparam int CW       = $clog2(LOCK_MAX + 1);
    localparam bit CAN_LOCK = (LOCK_MAX > 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic [CW-1:0] lock_cnt_inc_s;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

    logic          gnt0_raw_s, gnt1_raw_s;
    logic          gnt0_s, gnt1_s;
    logic          mem_we_s;
    logic [31:0]   mem_addr_s;
    logic [DW-1:0] mem_wd_s;

    // Grant decision: owner-exclusive while locked, otherwise round-robin (or fixed) on contention
    always_comb begin
        gnt0_raw_s = 1'b0;
        gnt1_raw_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0 && bus.req1) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                    gnt0_raw_s = 1'b1;
                    gnt1_raw_s = 1'b0;
`else
                    gnt0_raw_s = last_q;
                    gnt1_raw_s = ~last_q;
`endif
                end else begin
                    gnt0_raw_s = bus.req0;
                    gnt1_raw_s = bus.req1;
                end
            end
            OWN0: begin
                gnt0_raw_s = bus.req0;
                gnt1_raw_s = 1'b0;
            end
            OWN1: begin
                gnt0_raw_s = 1'b0;
                gnt1_raw_s = bus.req1;
            end
            default: begin
                gnt0_raw_s = 1'b0;
                gnt1_raw_s = 1'b0;
            end
        endcase
    end

    // Grants are suppressed for as long as reset is held, not just from the next edge
    assign gnt0_s = gnt0_raw_s & rst;
    assign gnt1_s = gnt1_raw_s & rst;

    // Memory port mux driven from whichever port holds the grant this cycle
    always_comb begin
        mem_we_s   = 1'b0;
        mem_addr_s = 32'd0;
        mem_wd_s   = {DW{1'b0}};
        if (gnt0_s) begin
            mem_we_s   = bus.we0;
            mem_addr_s = 32'(bus.addr0);
            mem_wd_s   = bus.wdata0;
        end else if (gnt1_s) begin
            mem_we_s   = bus.we1;
            mem_addr_s = 32'(bus.addr1);
            mem_wd_s   = bus.wdata1;
        end else begin
            mem_we_s   = 1'b0;
            mem_addr_s = 32'd0;
            mem_wd_s   = {DW{1'b0}};
        end
    end

    assign lock_cnt_inc_s = lock_cnt_q + {{(CW-1){1'b0}}, 1'b1};

    // Ownership FSM, lock counter and round-robin history
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        if (gnt0_s) begin
            last_d = 1'b0;
        end else if (gnt1_s) begin
            last_d = 1'b1;
        end else begin
            last_d = last_q;
        end
        case (state_q)
            IDLE: begin
                lock_cnt_d = {CW{1'b0}};
                if (CAN_LOCK && gnt0_s && bus.lock0) begin
                    state_d    = OWN0;
                    lock_cnt_d = {{(CW-1){1'b0}}, 1'b1};
                end else if (CAN_LOCK && gnt1_s && bus.lock1) begin
                    state_d    = OWN1;
                    lock_cnt_d = {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    state_d = IDLE;
                end
            end
            OWN0: begin
                // The count advances even on idle owner cycles so a silent owner cannot stall port 1 forever
                lock_cnt_d = lock_cnt_inc_s;
                if (!bus.lock0 || (lock_cnt_inc_s >= CW'(LOCK_MAX))) begin
                    state_d    = IDLE;
                    last_d     = 1'b0;
                    lock_cnt_d = {CW{1'b0}};
                end else begin
                    state_d = OWN0;
                end
            end
            OWN1: begin
                lock_cnt_d = lock_cnt_inc_s;
                if (!bus.lock1 || (lock_cnt_inc_s >= CW'(LOCK_MAX))) begin
                    state_d    = IDLE;
                    last_d     = 1'b1;
                    lock_cnt_d = {CW{1'b0}};
                end else begin
                    state_d = OWN1;
                end
            end
            default: begin
                state_d    = IDLE;
                lock_cnt_d = {CW{1'b0}};
            end
        endcase
    end

    // Read response capture; rdata holds its last value when no read completes
    always_comb begin
        rvalid0_d = gnt0_s & ~bus.we0;
        rvalid1_d = gnt1_s & ~bus.we1;
        if (rvalid0_d) begin
            rdata0_d = bus.mem_rd;
        end else begin
            rdata0_d = rdata0_q;
        end
        if (rvalid1_d) begin
            rdata1_d = bus.mem_rd;
        end else begin
            rdata1_d = rdata1_q;
        end
    end

    // State registers; port 0 wins the first contention after reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            lock_cnt_q <= {CW{1'b0}};
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= {DW{1'b0}};
            rdata1_q   <= {DW{1'b0}};
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign bus.gnt0     = gnt0_s;
    assign bus.gnt1     = gnt1_s;
    assign bus.rvalid0  = rvalid0_q;
    assign bus.rvalid1  = rvalid1_q;
    assign bus.rdata0   = rdata0_q;
    assign bus.rdata1   = rdata1_q;
    assign bus.mem_we   = mem_we_s;
    assign bus.mem_addr = mem_addr_s;
    assign bus.mem_wd   = mem_wd_s;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized bench for dmem_arbiter, checked against a transaction-level model
// that tracks owner, hold time, last winner and a shadow copy of memory.
module tb_dmem_arbiter;

    localparam int AW       = 5;
    localparam int DW       = 32;
    localparam int LOCK_MAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dmem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory attached to the arbiter: combinational read, write on the rising edge
    logic [DW-1:0] mem [0:31];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr[AW-1:0]] <= bus.mem_wd;
    end
    assign bus.mem_rd = mem[bus.mem_addr[AW-1:0]];

    int n_run  = 0;
    int n_fail = 0;

    // Reference model state
    int          m_owner;
    int          m_held;
    bit          m_last;
    bit          m_rv [2];
    logic [31:0] m_rd [2];
    logic [31:0] ref_mem [0:31];

    // Observations from the most recent checked cycle
    logic        o_g0, o_g1, o_we;
    logic [31:0] o_maddr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_last  = 1'b1;
        m_rv[0] = 1'b0;
        m_rv[1] = 1'b0;
        m_rd[0] = 32'd0;
        m_rd[1] = 32'd0;
    endtask

    task automatic drive(input bit r0, input bit w0, input bit l0, input int a0, input logic [31:0] d0,
                         input bit r1, input bit w1, input bit l1, input int a1, input logic [31:0] d1);
        bus.req0 = r0; bus.we0 = w0; bus.lock0 = l0; bus.addr0 = a0[AW-1:0]; bus.wdata0 = d0;
        bus.req1 = r1; bus.we1 = w1; bus.lock1 = l1; bus.addr1 = a1[AW-1:0]; bus.wdata1 = d1;
    endtask

    function automatic int predict();
        bit rq [2];
        rq[0] = bus.req0;
        rq[1] = bus.req1;
        if (m_owner >= 0) return rq[m_owner] ? m_owner : -1;
        if (rq[0] && rq[1]) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            return 0;
`else
            return m_last ? 0 : 1;
`endif
        end
        if (rq[0]) return 0;
        if (rq[1]) return 1;
        return -1;
    endfunction

    // One clock cycle: check mid-cycle outputs against the model, then advance the model at the edge
    task automatic cycle();
        int            g;
        bit            lk [2];
        bit            we [2];
        logic [AW-1:0] ad [2];
        logic [31:0]   wd [2];
        #4;
        lk[0] = bus.lock0; we[0] = bus.we0; ad[0] = bus.addr0; wd[0] = bus.wdata0;
        lk[1] = bus.lock1; we[1] = bus.we1; ad[1] = bus.addr1; wd[1] = bus.wdata1;
        g = predict();
        chk("gnt0", bus.gnt0, 32'(g == 0));
        chk("gnt1", bus.gnt1, 32'(g == 1));
        chk("mem_we", bus.mem_we, (g >= 0) ? 32'(we[g]) : 32'd0);
        chk("mem_addr", bus.mem_addr, (g >= 0) ? 32'(ad[g]) : 32'd0);
        chk("mem_wd", bus.mem_wd, (g >= 0) ? wd[g] : 32'd0);
        chk("rvalid0", bus.rvalid0, 32'(m_rv[0]));
        chk("rvalid1", bus.rvalid1, 32'(m_rv[1]));
        chk("rdata0", bus.rdata0, m_rd[0]);
        chk("rdata1", bus.rdata1, m_rd[1]);
        o_g0 = bus.gnt0; o_g1 = bus.gnt1; o_we = bus.mem_we; o_maddr = bus.mem_addr;
        @(posedge clk);
        m_rv[0] = 1'b0;
        m_rv[1] = 1'b0;
        if (g >= 0) begin
            m_last = g[0];
            if (we[g]) begin
                ref_mem[ad[g]] = wd[g];
            end else begin
                m_rv[g] = 1'b1;
                m_rd[g] = ref_mem[ad[g]];
            end
        end
        if (m_owner >= 0) begin
            m_held++;
            if (!lk[m_owner] || m_held >= LOCK_MAX) begin
                m_last  = m_owner[0];
                m_owner = -1;
                m_held  = 0;
            end
        end else if (g >= 0 && lk[g]) begin
            m_owner = g;
            m_held  = 1;
            if (m_held >= LOCK_MAX) m_owner = -1;
        end
        #1;
    endtask

    initial begin
        bit exp_g0;
        model_reset();
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;

        // Reset held with an active write request: no grant, no write strobe
        drive(1'b1, 1'b1, 1'b0, 2, 32'h1111_2222, 1'b1, 1'b0, 1'b0, 4, 32'd0);
        repeat (2) @(posedge clk);
        #3;
        chk("rst_gnt0", bus.gnt0, 32'd0);
        chk("rst_gnt1", bus.gnt1, 32'd0);
        chk("rst_mem_we", bus.mem_we, 32'd0);
        chk("rst_rvalid0", bus.rvalid0, 32'd0);
        chk("rst_rdata0", bus.rdata0, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Preload every word through port 1
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, 1'b0, 0, 32'd0, 1'b1, 1'b1, 1'b0, i, (i == 3) ? 32'hDEAD_BEEF : $urandom);
            cycle();
        end

        // Single read with one-cycle latency
        drive(1'b1, 1'b0, 1'b0, 3, 32'd0, 1'b0, 1'b0, 1'b0, 0, 32'd0);
        cycle();
        chk("t1_gnt0", 32'(o_g0), 32'd1);
        chk("t1_rvalid0", bus.rvalid0, 32'd1);
        chk("t1_rdata0", bus.rdata0, 32'hDEAD_BEEF);

        // Port 1 alone so that port 0 is next in the rotation, then four contended reads
        drive(1'b0, 1'b0, 1'b0, 0, 32'd0, 1'b1, 1'b0, 1'b0, 1, 32'd0);
        cycle();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, i + 8, 32'd0, 1'b1, 1'b0, 1'b0, i + 16, 32'd0);
            cycle();
`ifdef DMEM_ARB_FIXED_PRIO_EN
            exp_g0 = 1'b1;
`else
            exp_g0 = (i % 2 == 0);
`endif
            chk("t2_alt_gnt0", 32'(o_g0), 32'(exp_g0));
            chk("t2_alt_gnt1", 32'(o_g1), 32'(!exp_g0));
        end

        // Port 1 locked writes; port 0 waits LOCK_MAX cycles then wins
        drive(1'b0, 1'b0, 1'b0, 0, 32'd0, 1'b1, 1'b1, 1'b1, 20, 32'h0000_0020);
        cycle();
        chk("t3_lock_gnt1_0", 32'(o_g1), 32'd1);
        for (int i = 1; i < LOCK_MAX; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1, 32'd0, 1'b1, 1'b1, 1'b1, 20 + i, 32'h0000_0020 + i);
            cycle();
            chk("t3_lock_gnt1", 32'(o_g1), 32'd1);
            chk("t3_lock_gnt0", 32'(o_g0), 32'd0);
        end
        drive(1'b1, 1'b0, 1'b0, 1, 32'd0, 1'b1, 1'b1, 1'b1, 25, 32'h0000_0025);
        cycle();
        chk("t3_release_gnt0", 32'(o_g0), 32'd1);
        chk("t3_release_gnt1", 32'(o_g1), 32'd0);

        // Read-after-write across ports on consecutive cycles
        drive(1'b0, 1'b0, 1'b0, 0, 32'd0, 1'b1, 1'b1, 1'b0, 7, 32'h1234_5678);
        cycle();
        chk("t4_wr_gnt1", 32'(o_g1), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 7, 32'd0, 1'b0, 1'b0, 1'b0, 0, 32'd0);
        cycle();
        chk("t4_raw_rvalid0", bus.rvalid0, 32'd1);
        chk("t4_raw_rdata0", bus.rdata0, 32'h1234_5678);

        // Top word address: write, read back, then an idle cycle with no write strobe
        drive(1'b1, 1'b1, 1'b0, 31, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0, 0, 32'd0);
        cycle();
        chk("t5_wr_addr", o_maddr, 32'h0000_001F);
        chk("t5_wr_we", 32'(o_we), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 31, 32'd0, 1'b0, 1'b0, 1'b0, 0, 32'd0);
        cycle();
        chk("t5_rd_addr", o_maddr, 32'h0000_001F);
        chk("t5_rd_data", bus.rdata0, 32'hA5A5_A5A5);
        drive(1'b0, 1'b1, 1'b0, 31, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 0, 32'hFFFF_FFFF);
        cycle();
        chk("t5_idle_we", 32'(o_we), 32'd0);

        // Reset asserted while port 0 owns the memory with a read response pending
        drive(1'b1, 1'b0, 1'b1, 4, 32'd0, 1'b0, 1'b0, 1'b0, 0, 32'd0);
        cycle();
        drive(1'b1, 1'b0, 1'b1, 5, 32'd0, 1'b1, 1'b0, 1'b0, 6, 32'd0);
        #2;
        chk("t6_rvalid_before", bus.rvalid0, 32'd1);
        rst = 1'b0;
        #1;
        chk("t6_rst_gnt0", bus.gnt0, 32'd0);
        chk("t6_rst_gnt1", bus.gnt1, 32'd0);
        chk("t6_rst_rvalid0", bus.rvalid0, 32'd0);
        chk("t6_rst_mem_we", bus.mem_we, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 9, 32'd0, 1'b1, 1'b0, 1'b0, 10, 32'd0);
        cycle();
        chk("t6_after_gnt0", 32'(o_g0), 32'd1);

        // Randomized traffic checked cycle by cycle against the model
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 4) < 2,
                  int'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 4) < 2,
                  int'($urandom_range(0, 31)), $urandom);
            cycle();
        end

        drive(1'b0, 1'b0, 1'b0, 0, 32'd0, 1'b0, 1'b0, 1'b0, 0, 32'd0);
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
